wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Cycle sequencer for the washing-machine controller. Runs one wash program (fill, wash, drain, fill, rinse, drain, spin) against the water amount chosen by the water-amount selector. Drives the valves and motor, publishes `run_state`, and emits the `finish` pulse that returns the selector to its default level. Phase timing is counted in `tick_1s` strobes; all logic is synchronous to one clock.

## Interface
Parameters:
- WASH_T, 9: wash agitation duration in ticks (1..63)
- RINSE_T, 6: rinse agitation duration in ticks (1..63)
- SPIN_T, 3: spin duration in ticks (1..63)

Ports:
- clk  in  1  system clock; one clock domain only
- rst  in  1  reset, synchronous, active-high
- power_on  in  1  power switch level; low = abort to IDLE
- start_pause  in  1  one-cycle pulse; starts from IDLE, toggles pause otherwise
- tick_1s  in  1  one-cycle timebase strobe
- water_level  in  3  selected amount 0..5, sampled at start
- run_state  out  2  0 = idle, 1 = wash, 2 = rinse, 3 = spin
- fill_valve  out  1  inlet valve open
- drain_valve  out  1  outlet valve open
- motor_on  out  1  drum motor enabled
- spin_fast  out  1  high-speed spin; only with motor_on
- paused  out  1  program frozen
- finish  out  1  one-cycle pulse at program completion
- remaining_time  out  8  ticks left in the whole program

## Operation
- Phases, in order: IDLE, FILL_W, WASH, DRAIN_W, FILL_R, RINSE, DRAIN_R, SPIN, then back to IDLE.
- run_state mapping:
  - IDLE → 0
  - FILL_W, WASH, DRAIN_W → 1
  - FILL_R, RINSE, DRAIN_R → 2
  - SPIN → 3
- Start: in IDLE with power_on=1, a start_pause pulse does all of the following:
  - latches L = max(water_level, 1);
  - loads the phase counter with L;
  - loads remaining_time with 4·L + WASH_T + RINSE_T + SPIN_T;
  - enters FILL_W.
- Durations: fill and drain phases last L ticks; WASH, RINSE and SPIN last their parameter values.
- Counting:
  - A tick is counted only when the state is not IDLE and paused=0.
  - Each counted tick decrements both the phase counter and remaining_time.
  - When a counted tick arrives with the phase counter at 1, the block advances to the next phase and loads that phase's duration.
- Outputs are decoded from the phase and are forced to 0 while paused:
  - fill_valve in FILL_*.
  - drain_valve in DRAIN_* and SPIN.
  - motor_on in WASH, RINSE and SPIN.
  - spin_fast in SPIN only.
- Completion: the counted tick that expires SPIN moves the block to IDLE, asserts finish for exactly one cycle, and leaves remaining_time at 0.
- Pause: a start_pause pulse outside IDLE toggles paused. While paused, the phase, phase counter and remaining_time hold, and run_state holds its value.
- power_on=0: in the next cycle, same effect as rst, except that finish stays 0. start_pause is ignored while power is off.
- water_level changes after start have no effect until the next start.

## Timing
- Reset values: IDLE, run_state=0, all valves/motor/spin 0, paused=0, finish=0, remaining_time=0, phase counter 0.
- All state is registered. Outputs are decoded from registered state with no combinational path from inputs to outputs.
- Start latency: the start_pause pulse at edge n puts the block in FILL_W with fill_valve=1 from edge n+1.
- Phase advance is visible on the edge that samples the expiring tick.
- Simultaneous start_pause and tick_1s:
  - The tick is judged against the current, pre-toggle paused value: running → tick counted, then pause applied; paused → tick ignored, then resume.
  - In IDLE, a tick in the same cycle as start is ignored.
- rst or power_on=0 mid-program aborts immediately. There is no finish pulse and no resume.
- Back-to-back ticks on consecutive cycles are each counted, including across a phase boundary.

## Structure
- Package wash_pkg holds:
  - the phase enum (9 states);
  - run_state codes RS_IDLE, RS_WASH, RS_RINSE, RS_SPIN;
  - default duration constants;
  - the remaining_time width (8).
- Sub-module phase_timer: a 6-bit down-counter with load, load value, count enable and an `expire` output (counter==1 and enable). The sequencer FSM instantiates it once and owns remaining_time itself.

## Test plan
- water_level=2, start, 26 ticks → phases FILL_W 2, WASH 9, DRAIN_W 2, FILL_R 2, RINSE 6, DRAIN_R 2, SPIN 3; remaining_time 26→0; finish high for 1 cycle; run_state sequence 1,2,3,0.
- water_level=0, start → L=1, remaining_time=22, FILL_W lasts 1 tick.
- Pause after 5 ticks, apply 10 ticks, resume → remaining_time holds at 21, all valves and motor 0 while paused, run_state=1, program then completes after 21 more ticks.
- start_pause and tick_1s in the same cycle while running in WASH → tick counted (remaining_time −1) and paused=1; repeat while paused → tick not counted and paused=0.
- power_on dropped during RINSE (run_state=2) → next cycle IDLE, all outputs 0, finish never asserted; rst mid-SPIN → same result.
- Change water_level 2→5 during FILL_W → fill still ends after 2 ticks and total stays 26.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine cycle sequencer.
package wash_pkg;

  // Program phases in execution order. PhSpare is never entered; the
  // sequencer treats it as IDLE so a corrupted state register recovers.
  typedef enum logic [3:0] {
    PhIdle,
    PhFillW,
    PhWash,
    PhDrainW,
    PhFillR,
    PhRinse,
    PhDrainR,
    PhSpin,
    PhSpare
  } phase_e;

  localparam logic [1:0] RS_IDLE  = 2'd0;
  localparam logic [1:0] RS_WASH  = 2'd1;
  localparam logic [1:0] RS_RINSE = 2'd2;
  localparam logic [1:0] RS_SPIN  = 2'd3;

  localparam int unsigned WASH_T_DEF  = 9;
  localparam int unsigned RINSE_T_DEF = 6;
  localparam int unsigned SPIN_T_DEF  = 3;

  localparam int unsigned REM_W = 8;
  localparam int unsigned CNT_W = 6;

  // Successor phase; SPIN wraps back to IDLE.
  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PhFillW:  next_phase = PhWash;
      PhWash:   next_phase = PhDrainW;
      PhDrainW: next_phase = PhFillR;
      PhFillR:  next_phase = PhRinse;
      PhRinse:  next_phase = PhDrainR;
      PhDrainR: next_phase = PhSpin;
      default:  next_phase = PhIdle;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase down-counter; expire flags the enabled tick that ends a phase.
module phase_timer
  import wash_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over counting; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = en && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/wash_sequencer.sv
// Wash-program sequencer: phase FSM, pause control, total-time countdown.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned WASH_T  = WASH_T_DEF,
  parameter int unsigned RINSE_T = RINSE_T_DEF,
  parameter int unsigned SPIN_T  = SPIN_T_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power_on,
  input  logic             start_pause,
  input  logic             tick_1s,
  input  logic [2:0]       water_level,
  output logic [1:0]       run_state,
  output logic             fill_valve,
  output logic             drain_valve,
  output logic             motor_on,
  output logic             spin_fast,
  output logic             paused,
  output logic             finish,
  output logic [REM_W-1:0] remaining_time
);

  localparam logic [REM_W-1:0] AGIT_SUM = REM_W'(WASH_T + RINSE_T + SPIN_T);

  phase_e           phase_q, phase_d;
  logic             paused_q, paused_d;
  logic             finish_q, finish_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [2:0]       level_q, level_d;

  logic             clear;
  logic             count;
  logic             expire;
  logic             t_load;
  logic [CNT_W-1:0] t_load_val;
  logic [2:0]       start_lvl;
  phase_e           succ;

  // Power loss acts as a reset one edge later, without a finish pulse.
  assign clear     = rst || !power_on;
  assign count     = (phase_q != PhIdle) && !paused_q && tick_1s;
  assign start_lvl = (water_level == 3'd0) ? 3'd1 : water_level;
  assign succ      = next_phase(phase_q);

  phase_timer u_timer (
    .clk      (clk),
    .rst      (clear),
    .load     (t_load),
    .load_val (t_load_val),
    .en       (count),
    .expire   (expire)
  );

  // Next-state logic: start, counted ticks, phase advance and pause toggle.
  always_comb begin
    phase_d    = phase_q;
    paused_d   = paused_q;
    finish_d   = 1'b0;
    rem_d      = rem_q;
    level_d    = level_q;
    t_load     = 1'b0;
    t_load_val = '0;

    if (phase_q == PhIdle || phase_q == PhSpare) begin
      phase_d  = PhIdle;
      paused_d = 1'b0;
      if (start_pause) begin
        phase_d    = PhFillW;
        level_d    = start_lvl;
        t_load     = 1'b1;
        t_load_val = {3'b000, start_lvl};
        rem_d      = {3'b000, start_lvl, 2'b00} + AGIT_SUM;
      end
    end else begin
      // Tick is judged against pre-toggle pause state.
      if (start_pause) begin
        paused_d = !paused_q;
      end
      if (count) begin
        rem_d = rem_q - 1'b1;
        if (expire) begin
          phase_d = succ;
          t_load  = 1'b1;
          case (succ)
            PhWash:  t_load_val = CNT_W'(WASH_T);
            PhRinse: t_load_val = CNT_W'(RINSE_T);
            PhSpin:  t_load_val = CNT_W'(SPIN_T);
            PhIdle:  t_load_val = '0;
            default: t_load_val = {3'b000, level_q};
          endcase
          if (succ == PhIdle) begin
            finish_d = 1'b1;
            paused_d = 1'b0;
            rem_d    = '0;
          end
        end
      end
    end
  end

  // State registers; rst and power loss both abort to IDLE.
  always_ff @(posedge clk) begin
    if (clear) begin
      phase_q  <= PhIdle;
      paused_q <= 1'b0;
      finish_q <= 1'b0;
      rem_q    <= '0;
      level_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      paused_q <= paused_d;
      finish_q <= finish_d;
      rem_q    <= rem_d;
      level_q  <= level_d;
    end
  end

  // Output decode from registered phase; actuators are off while paused.
  always_comb begin
    run_state   = RS_IDLE;
    fill_valve  = 1'b0;
    drain_valve = 1'b0;
    motor_on    = 1'b0;
    spin_fast   = 1'b0;
    case (phase_q)
      PhFillW:  begin run_state = RS_WASH;  fill_valve  = !paused_q; end
      PhWash:   begin run_state = RS_WASH;  motor_on    = !paused_q; end
      PhDrainW: begin run_state = RS_WASH;  drain_valve = !paused_q; end
      PhFillR:  begin run_state = RS_RINSE; fill_valve  = !paused_q; end
      PhRinse:  begin run_state = RS_RINSE; motor_on    = !paused_q; end
      PhDrainR: begin run_state = RS_RINSE; drain_valve = !paused_q; end
      PhSpin: begin
        run_state   = RS_SPIN;
        drain_valve = !paused_q;
        motor_on    = !paused_q;
        spin_fast   = !paused_q;
      end
      default: run_state = RS_IDLE;
    endcase
  end

  assign paused         = paused_q;
  assign finish         = finish_q;
  assign remaining_time = rem_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench: directed program runs plus randomized stimulus
// compared each cycle against an elapsed-time program model.
module tb_wash_sequencer;

  localparam int WT = 9;
  localparam int RT = 6;
  localparam int ST = 3;

  logic       clk = 1'b0;
  logic       rst, power_on, start_pause, tick_1s;
  logic [2:0] water_level;
  logic [1:0] run_state;
  logic       fill_valve, drain_valve, motor_on, spin_fast, paused, finish;
  logic [7:0] remaining_time;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Model: program = 7 phase durations; position = counted ticks elapsed.
  bit m_act, m_paused, m_fin;
  int m_e, m_total;
  int m_dur[7];

  wash_sequencer #(
    .WASH_T  (WT),
    .RINSE_T (RT),
    .SPIN_T  (ST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .power_on       (power_on),
    .start_pause    (start_pause),
    .tick_1s        (tick_1s),
    .water_level    (water_level),
    .run_state      (run_state),
    .fill_valve     (fill_valve),
    .drain_valve    (drain_valve),
    .motor_on       (motor_on),
    .spin_fast      (spin_fast),
    .paused         (paused),
    .finish         (finish),
    .remaining_time (remaining_time)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_idx();
    int acc = 0;
    for (int i = 0; i < 7; i++) begin
      acc += m_dur[i];
      if (m_e < acc) return i;
    end
    return 6;
  endfunction

  task automatic model_step(input bit r, input bit p, input bit sp, input bit tk,
                            input int wl);
    int lv;
    if (r || !p) begin
      m_act = 0; m_paused = 0; m_fin = 0; m_e = 0; m_total = 0;
    end else begin
      m_fin = 0;
      if (!m_act) begin
        if (sp) begin
          lv = (wl < 1) ? 1 : wl;
          m_dur = '{lv, WT, lv, lv, RT, lv, ST};
          m_total = 4 * lv + WT + RT + ST;
          m_e = 0;
          m_act = 1;
        end
      end else begin
        if (tk && !m_paused) m_e++;
        if (m_e == m_total) begin
          m_act = 0; m_fin = 1; m_paused = 0; m_e = 0; m_total = 0;
        end else if (sp) begin
          m_paused = !m_paused;
        end
      end
    end
  endtask

  task automatic check_all();
    int idx, rs;
    bit f, d, m, s;
    idx = m_idx();
    rs = 0; f = 0; d = 0; m = 0; s = 0;
    if (m_act) begin
      rs = idx / 3 + 1;
      f = (idx == 0 || idx == 3);
      d = (idx == 2 || idx == 5 || idx == 6);
      m = (idx == 1 || idx == 4 || idx == 6);
      s = (idx == 6);
      if (m_paused) begin f = 0; d = 0; m = 0; s = 0; end
    end
    check("run_state", 32'(run_state), rs);
    check("fill_valve", 32'(fill_valve), 32'(f));
    check("drain_valve", 32'(drain_valve), 32'(d));
    check("motor_on", 32'(motor_on), 32'(m));
    check("spin_fast", 32'(spin_fast), 32'(s));
    check("paused", 32'(paused), 32'(m_paused));
    check("finish", 32'(finish), 32'(m_fin));
    check("remaining_time", 32'(remaining_time), m_act ? m_total - m_e : 0);
  endtask

  task automatic step(input bit r, input bit p, input bit sp, input bit tk, input int wl);
    @(negedge clk);
    rst = r; power_on = p; start_pause = sp; tick_1s = tk; water_level = 3'(wl);
    @(posedge clk);
    model_step(r, p, sp, tk, wl);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1; power_on = 1; start_pause = 0; tick_1s = 0; water_level = 0;
    m_act = 0; m_paused = 0; m_fin = 0; m_e = 0; m_total = 0;
    m_dur = '{0, 0, 0, 0, 0, 0, 0};
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("reset_rem", 32'(remaining_time), 0);
    check("reset_state", 32'(run_state), 0);

    // Full program at level 2, water_level changed mid-fill.
    step(0, 1, 1, 1, 2);
    check("start_rem_l2", 32'(remaining_time), 26);
    check("start_fill", 32'(fill_valve), 1);
    step(0, 1, 0, 1, 5);
    step(0, 1, 0, 1, 5);
    check("fill_end_l2", 32'(motor_on), 1);
    for (int i = 0; i < 24; i++) step(0, 1, 0, 1, 5);
    check("finish_l2", 32'(finish), 1);
    check("done_rem", 32'(remaining_time), 0);
    step(0, 1, 0, 0, 0);
    check("finish_one_cycle", 32'(finish), 0);

    // Level 0 clamps to 1.
    step(0, 1, 1, 0, 0);
    check("start_rem_l0", 32'(remaining_time), 22);
    step(0, 1, 0, 1, 0);
    check("fill_one_tick", 32'(run_state), 1);
    check("fill_over", 32'(motor_on), 1);
    step(0, 0, 0, 0, 0);

    // Pause after 5 ticks, 10 ignored ticks, resume, simultaneous pause+tick.
    step(0, 1, 1, 0, 2);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 2);
    step(0, 1, 1, 0, 2);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 2);
    check("pause_hold", 32'(remaining_time), 21);
    step(0, 1, 1, 0, 2);
    step(0, 1, 1, 1, 2);
    check("pause_tick_counted", 32'(remaining_time), 20);
    step(0, 1, 1, 1, 2);
    check("resume_tick_ignored", 32'(remaining_time), 20);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 2);
    check("finish_after_pause", 32'(finish), 1);

    // Randomized mix including power drops and resets mid-program.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(299) == 0, $urandom_range(199) != 0,
           $urandom_range(14) == 0, $urandom_range(1) == 0, $urandom_range(5));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
